// File: rtl/alu_uart_interface.sv
// alu_uart_interface
//   Byte-serial front end for a combinational ALU. Three UART bytes are
//   collected in order (operand A, operand B, opcode). They are held on the
//   ALU inputs while the ALU result is captured. The result is then handed to
//   a UART transmitter as a single byte, with a watchdog on the transmitter's
//   completion pulse.
//
// Ports
//   clk      : rising-edge clock
//   rst_n    : synchronous active-low reset
//   rx_data  : received byte, valid while rx_done is high
//   rx_done  : one-cycle pulse marking a received byte
//   alu_out  : combinational ALU result for the current A/B/opcode
//   tx_done  : one-cycle pulse marking the end of a transmitted byte
//   A, B     : registered operands to the ALU
//   opcode   : registered opcode to the ALU (low OPCODE_LEN bits of the byte)
//   tx_data  : registered result byte for the transmitter
//   tx_start : one-cycle request to transmit tx_data
//   busy     : high while the result is latched or being transmitted
//   timeout  : one-cycle pulse when the transmitter never reported tx_done
module alu_uart_interface #(
  parameter int BUS_LEN        = 8,
  parameter int OPCODE_LEN     = 6,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BUS_LEN-1:0]    rx_data,
  input  logic                  rx_done,
  input  logic [BUS_LEN-1:0]    alu_out,
  input  logic                  tx_done,
  output logic [BUS_LEN-1:0]    A,
  output logic [BUS_LEN-1:0]    B,
  output logic [OPCODE_LEN-1:0] opcode,
  output logic [BUS_LEN-1:0]    tx_data,
  output logic                  tx_start,
  output logic                  busy,
  output logic                  timeout
);

  typedef enum logic [2:0] {
    S_A       = 3'd0,
    S_B       = 3'd1,
    S_OP      = 3'd2,
    S_LATCH   = 3'd3,
    S_WAIT_TX = 3'd4
  } state_t;

  // Last counter value before the watchdog fires.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] counter;
  logic        expire;

  // Upper opcode-byte bits are intentionally discarded.
  logic unused_rx_bits;
  assign unused_rx_bits = ^rx_data[BUS_LEN-1:OPCODE_LEN];

  // Watchdog expiry only counts when tx_done does not arrive in that cycle.
  assign expire = (state == S_WAIT_TX) && !tx_done && (counter == CNT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_A;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_A:       if (rx_done) state_next = S_B;
      S_B:       if (rx_done) state_next = S_OP;
      S_OP:      if (rx_done) state_next = S_LATCH;
      S_LATCH:   state_next = S_WAIT_TX;
      S_WAIT_TX: if (tx_done || expire) state_next = S_A;
      default:   state_next = S_A;
    endcase
  end

  // Operand capture; bytes arriving in S_LATCH/S_WAIT_TX are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      A      <= '0;
      B      <= '0;
      opcode <= '0;
    end else if (rx_done) begin
      case (state)
        S_A:     A      <= rx_data;
        S_B:     B      <= rx_data;
        S_OP:    opcode <= rx_data[OPCODE_LEN-1:0];
        default: ;
      endcase
    end
  end

  // Result capture, transmit request and watchdog.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_data  <= '0;
      tx_start <= 1'b0;
      timeout  <= 1'b0;
      counter  <= '0;
    end else begin
      tx_start <= 1'b0;
      timeout  <= expire;
      if (state == S_LATCH) begin
        tx_data  <= alu_out;
        tx_start <= 1'b1;
        counter  <= '0;
      end else if (state == S_WAIT_TX) begin
        counter  <= counter + 16'd1;
      end
    end
  end

  assign busy = (state == S_LATCH) || (state == S_WAIT_TX);

endmodule

// File: tb/tb_alu_uart_interface.sv
// Directed bench for alu_uart_interface with a small behavioural ALU.
module tb_alu_uart_interface;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_done;
  logic [7:0] alu_out;
  logic       tx_done;
  logic [7:0] A;
  logic [7:0] B;
  logic [5:0] opcode;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_uart_interface #(
    .BUS_LEN(8),
    .OPCODE_LEN(6),
    .TIMEOUT_CYCLES(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .alu_out(alu_out),
    .tx_done(tx_done),
    .A(A),
    .B(B),
    .opcode(opcode),
    .tx_data(tx_data),
    .tx_start(tx_start),
    .busy(busy),
    .timeout(timeout)
  );

  // Reference ALU
  always_comb begin
    alu_out = 8'h00;
    case (opcode)
      6'h20: alu_out = A + B;
      6'h22: alu_out = A - B;
      6'h24: alu_out = A & B;
      6'h25: alu_out = A | B;
      6'h26: alu_out = A ^ B;
      6'h27: alu_out = ~(A | B);
      6'h03: alu_out = 8'($signed(A) >>> B);
      6'h02: alu_out = A >> B;
      default: alu_out = 8'h00;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  task automatic transact(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] op, input logic [7:0] exp);
    send(a);
    send(b);
    send(op);
    step();
    chk({tag, "_tx_start"}, tx_start, 1);
    chk({tag, "_tx_data"}, tx_data, exp);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk({tag, "_busy_after"}, busy, 0);
  endtask

  initial begin
    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    tx_done = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_A", A, 0);
    chk("rst_B", B, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);

    // ADD with detailed timing
    send(8'h05);
    chk("add_A", A, 8'h05);
    chk("add_busy_sb", busy, 0);
    send(8'h03);
    chk("add_B", B, 8'h03);
    send(8'h20);
    chk("add_opcode", opcode, 6'h20);
    chk("add_busy_latch", busy, 1);
    chk("add_tx_start_n1", tx_start, 0);
    step();
    chk("add_tx_start_n2", tx_start, 1);
    chk("add_tx_data", tx_data, 8'h08);
    step();
    chk("add_tx_start_n3", tx_start, 0);
    chk("add_busy_wait", busy, 1);
    chk("add_tx_data_hold", tx_data, 8'h08);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("add_busy_done", busy, 0);
    chk("add_timeout", timeout, 0);

    // Signed / shift / opcode stripping
    transact("sub", 8'h03, 8'h05, 8'h22, 8'hFE);
    transact("sra", 8'h80, 8'h02, 8'h03, 8'hE0);
    transact("srl", 8'h80, 8'h02, 8'h02, 8'h20);
    transact("and", 8'h0F, 8'hFF, 8'hE4, 8'h0F);
    chk("and_opcode_strip", opcode, 6'h24);
    chk("hold_A", A, 8'h0F);

    // Drop bytes while busy
    send(8'h11);
    send(8'h22);
    send(8'h20);
    send(8'h77);
    chk("drop_A", A, 8'h11);
    chk("drop_B", B, 8'h22);
    chk("drop_opcode", opcode, 6'h20);
    chk("drop_tx_data", tx_data, 8'h33);
    chk("drop_busy", busy, 1);
    rx_data = 8'h77;
    rx_done = 1'b1;
    tx_done = 1'b1;
    step();
    rx_done = 1'b0;
    tx_done = 1'b0;
    chk("drop_tie_busy", busy, 0);
    chk("drop_tie_A", A, 8'h11);
    chk("drop_tie_tx_start", tx_start, 0);
    send(8'h01);
    chk("drop_next_A", A, 8'h01);
    chk("drop_next_B_hold", B, 8'h22);
    send(8'h02);
    send(8'h20);
    step();
    chk("drop_next_tx_data", tx_data, 8'h03);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;

    // Stray tx_done in S_A is ignored
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    send(8'h05);
    chk("stray_txdone_A", A, 8'h05);

    // Timeout: tx_start cycle is wait cycle 0; timeout lands 10 cycles later
    send(8'h05);
    send(8'h20);
    step();
    chk("to_tx_start", tx_start, 1);
    for (int i = 1; i <= 9; i++) begin
      step();
      chk("to_early_timeout", timeout, 0);
      chk("to_early_busy", busy, 1);
    end
    step();
    chk("to_timeout", timeout, 1);
    chk("to_busy", busy, 0);
    step();
    chk("to_timeout_pulse", timeout, 0);
    send(8'h09);
    chk("to_next_A", A, 8'h09);

    // Tie: tx_done on the expiry cycle
    send(8'h0A);
    send(8'h20);
    step();
    chk("tie_tx_data", tx_data, 8'h13);
    for (int i = 1; i <= 9; i++) step();
    chk("tie_busy_pre", busy, 1);
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    chk("tie_timeout", timeout, 0);
    chk("tie_busy", busy, 0);
    step();
    chk("tie_timeout_late", timeout, 0);

    // Reset mid-transmission
    send(8'h05);
    send(8'h03);
    send(8'h20);
    step();
    step();
    step();
    chk("rst2_pre_busy", busy, 1);
    rst_n = 1'b0;
    step();
    step();
    step();
    chk("rst2_A", A, 0);
    chk("rst2_B", B, 0);
    chk("rst2_opcode", opcode, 0);
    chk("rst2_tx_data", tx_data, 0);
    chk("rst2_tx_start", tx_start, 0);
    chk("rst2_timeout", timeout, 0);
    chk("rst2_busy", busy, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rst2_no_restart", tx_start | timeout | busy, 0);
    end
    transact("rst2_add", 8'h02, 8'h03, 8'h20, 8'h05);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_uart_interface.md
# alu_uart_interface

Byte-serial front end for the ALU: collects operand A, operand B and the opcode from a UART receiver, drives them onto the ALU inputs, and captures the ALU result. It then hands the result to a UART transmitter as one byte. It sits between the UART RX/TX pair and the combinational ALU. It is the producer of the ALU's A/B/opcode interface and the consumer of its `out` bus.

## Interface
Parameters:
- `BUS_LEN`, 8: data width of operands, result and UART bytes.
- `OPCODE_LEN`, 6: opcode width driven to the ALU.
- `TIMEOUT_CYCLES`, 50000: cycles to wait for `tx_done` before abandoning a transmission. Must be ≥ 1 and < 2^16.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `rx_data`, in, BUS_LEN: byte from the UART receiver. Valid only while `rx_done` is high.
- `rx_done`, in, 1: one-cycle pulse marking a received byte.
- `alu_out`, in, BUS_LEN: ALU result, combinational from `A`, `B` and `opcode`.
- `tx_done`, in, 1: one-cycle pulse from the transmitter marking the end of the byte.
- `A`, out, BUS_LEN: registered operand A to the ALU.
- `B`, out, BUS_LEN: registered operand B to the ALU.
- `opcode`, out, OPCODE_LEN: registered opcode to the ALU.
- `tx_data`, out, BUS_LEN: registered result byte to the transmitter.
- `tx_start`, out, 1: one-cycle pulse requesting transmission of `tx_data`.
- `busy`, out, 1: high while a result is being latched or transmitted.
- `timeout`, out, 1: one-cycle pulse when `TIMEOUT_CYCLES` expires in S_WAIT_TX.

## Operation
FSM states and transitions:
- **S_A:** on `rx_done`, A <= rx_data, then go to S_B.
- **S_B:** on `rx_done`, B <= rx_data, then go to S_OP.
- **S_OP:** on `rx_done`, opcode <= rx_data[OPCODE_LEN-1:0] (upper bits discarded), then go to S_LATCH.
- **S_LATCH:** unconditional. tx_data <= alu_out, tx_start <= 1, counter cleared, then go to S_WAIT_TX.
- **S_WAIT_TX:** tx_start <= 0 and the counter increments each cycle.
  - On `tx_done`, go to S_A.
  - Otherwise, when counter == TIMEOUT_CYCLES-1, timeout <= 1 and go to S_A.

Data-path rules:
- A, B and opcode hold their value until overwritten. They are not cleared after a transaction.
- The opcode is forwarded unmodified, and undefined opcodes are passed through. The ALU's own default then yields 0.
- No arithmetic is done in this block. `tx_data` is a straight capture of `alu_out`.

Boundary conditions:
- `rx_done` in S_LATCH or S_WAIT_TX: the byte is dropped, with no state change and no register update.
- `tx_done` and `rx_done` in the same cycle in S_WAIT_TX: `tx_done` is honoured and the byte is dropped.
- `tx_done` and timeout expiry in the same cycle: `tx_done` wins and `timeout` stays 0.
- `tx_done` in any state other than S_WAIT_TX: ignored.
- `busy` = (state == S_LATCH) || (state == S_WAIT_TX). It is decoded from registered state.

Reset (`rst_n` low at a rising edge, from any state):
- State returns to S_A.
- A, B, opcode, tx_data and the counter all return to 0.
- `tx_start`, `timeout` and `busy` return to 0.
- A transmission in flight is abandoned without a `tx_start` re-pulse.

## Timing
- Byte capture: `rx_done` sampled high at edge N puts the new register value on the output after edge N.
- Opcode to result: opcode captured at edge N, then `tx_data` valid and `tx_start` high after edge N+1. `tx_start` is low again after edge N+2.
  - Latency from the opcode byte's `rx_done` to `tx_start` is 2 edges.
- `tx_start` is exactly one cycle wide per transaction. `tx_data` is stable from the `tx_start` cycle until the next S_LATCH.
- Timeout: `timeout` pulses in the cycle after the edge ending the TIMEOUT_CYCLES-th cycle spent in S_WAIT_TX. S_A is entered at the same edge.
- Back-to-back: the first byte of the next transaction is accepted in the cycle after the edge that saw `tx_done`.

## Test plan
Benches instantiate this block with the ALU and model the UART handshakes.
- **Reset:** assert `rst_n`=0 for 3 cycles mid-S_WAIT_TX -> all outputs 0, state S_A, no `tx_start` afterwards.
- **ADD:** bytes 0x05, 0x03, 0x20 -> A=0x05, B=0x03, opcode=0x20; `tx_start` 2 edges after the third `rx_done` with `tx_data`=0x08. A `tx_done` pulse then returns `busy` to 0.
- **Signed ops:** SUB 0x03, 0x05, 0x22 -> `tx_data`=0xFE; SRA 0x80, 0x02, 0x03 -> 0xE0; SRL 0x80, 0x02, 0x02 -> 0x20; opcode byte 0xE4 (upper bits stripped -> AND) with 0x0F, 0xFF -> 0x0F.
- **Drop while busy:** extra `rx_done` (0x77) during S_WAIT_TX, including one coincident with `tx_done` -> A unchanged, next transaction starts cleanly at S_A.
- **Timeout:** `TIMEOUT_CYCLES`=10, never send `tx_done` -> `timeout` pulses once exactly 10 cycles after the `tx_start` cycle, state S_A, `busy` 0.
- **Tie:** `tx_done` on the expiry cycle -> `timeout` remains 0.
